// File: rtl/riscv_id_pkg.sv
// Shared RV32I ISA constants for the decode and execute stages.
package riscv_id_pkg;

    localparam int unsigned XlenDef = 32;
    localparam int unsigned RegaDef = 5;

    localparam logic [6:0] OpcodeOp    = 7'b0110011;
    localparam logic [6:0] OpcodeOpImm = 7'b0010011;

    typedef enum logic [2:0] {
        F3AddSub = 3'b000,
        F3Sll    = 3'b001,
        F3Slt    = 3'b010,
        F3Sltu   = 3'b011,
        F3Xor    = 3'b100,
        F3Sr     = 3'b101,
        F3Or     = 3'b110,
        F3And    = 3'b111
    } funct3_e;

endpackage

// File: rtl/riscv_regfile.sv
// Integer register file: two asynchronous read ports, one synchronous write port.
module riscv_regfile
    import riscv_id_pkg::*;
#(
    parameter int unsigned XLEN = XlenDef,
    parameter int unsigned REGA = RegaDef
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [REGA-1:0] ra1,
    output logic [XLEN-1:0] rd1,
    input  logic [REGA-1:0] ra2,
    output logic [XLEN-1:0] rd2,
    input  logic            we,
    input  logic [REGA-1:0] wa,
    input  logic [XLEN-1:0] wd
);

    localparam int unsigned NumRegs = 2 ** REGA;

    logic [XLEN-1:0] regs_q [NumRegs];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NumRegs; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we && wa != '0) begin
            regs_q[wa] <= wd;
        end
    end

    // x0 is hardwired to zero regardless of array contents.
    assign rd1 = (ra1 == '0) ? '0 : regs_q[ra1];
    assign rd2 = (ra2 == '0) ? '0 : regs_q[ra2];

endmodule

// File: rtl/riscv_id.sv
// RV32I decode stage for OP / OP-IMM with registered operand outputs.
// Optional RISCV_WB_BYPASS_EN forwards same-cycle writeback data into the operands.
module riscv_id
    import riscv_id_pkg::*;
#(
    parameter int unsigned XLEN = XlenDef,
    parameter int unsigned REGA = RegaDef
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     inst,
    input  logic            stall,
    input  logic            wb_en,
    input  logic [REGA-1:0] wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            out_valid,
    output logic [REGA-1:0] rdi,
    output logic [XLEN-1:0] a,
    output logic [XLEN-1:0] b,
    output logic [5:0]      shamt,
    output logic [2:0]      funct3,
    output logic            invertb,
    output logic            illegal
);

    logic [REGA-1:0] rs1, rs2;
    logic [XLEN-1:0] rf_a, rf_b, op_a, op_b;

    logic            valid_d, valid_q;
    logic [REGA-1:0] rdi_d, rdi_q;
    logic [XLEN-1:0] a_d, a_q, b_d, b_q;
    logic [5:0]      shamt_d, shamt_q;
    logic [2:0]      funct3_d, funct3_q;
    logic            invertb_d, invertb_q;
    logic            illegal_d, illegal_q;

    assign rs1 = REGA'(inst[19:15]);
    assign rs2 = REGA'(inst[24:20]);

    riscv_regfile #(
        .XLEN(XLEN),
        .REGA(REGA)
    ) u_regfile (
        .clk (clk),
        .rst (rst),
        .ra1 (rs1),
        .rd1 (rf_a),
        .ra2 (rs2),
        .rd2 (rf_b),
        .we  (wb_en),
        .wa  (wb_rd),
        .wd  (wb_data)
    );

`ifdef RISCV_WB_BYPASS_EN
    assign op_a = (wb_en && wb_rd != '0 && wb_rd == rs1) ? wb_data : rf_a;
    assign op_b = (wb_en && wb_rd != '0 && wb_rd == rs2) ? wb_data : rf_b;
`else
    assign op_a = rf_a;
    assign op_b = rf_b;
`endif

    assign in_ready = !stall;

    always_comb begin
        valid_d   = valid_q;
        rdi_d     = rdi_q;
        a_d       = a_q;
        b_d       = b_q;
        shamt_d   = shamt_q;
        funct3_d  = funct3_q;
        invertb_d = invertb_q;
        illegal_d = 1'b0;
        if (!stall) begin
            if (in_valid) begin
                case (inst[6:0])
                    OpcodeOp: begin
                        valid_d   = 1'b1;
                        rdi_d     = REGA'(inst[11:7]);
                        a_d       = op_a;
                        b_d       = op_b;
                        shamt_d   = {1'b0, op_b[4:0]};
                        funct3_d  = inst[14:12];
                        invertb_d = inst[30];
                    end
                    OpcodeOpImm: begin
                        valid_d   = 1'b1;
                        rdi_d     = REGA'(inst[11:7]);
                        a_d       = op_a;
                        b_d       = XLEN'($signed(inst[31:20]));
                        shamt_d   = {1'b0, inst[24:20]};
                        funct3_d  = inst[14:12];
                        // Only srai uses bit 30; for other immediates it is just an imm bit.
                        invertb_d = (funct3_e'(inst[14:12]) == F3Sr) && inst[30];
                    end
                    default: begin
                        valid_d   = 1'b0;
                        rdi_d     = '0;
                        illegal_d = 1'b1;
                    end
                endcase
            end else begin
                valid_d = 1'b0;
                rdi_d   = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q   <= 1'b0;
            rdi_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            shamt_q   <= '0;
            funct3_q  <= '0;
            invertb_q <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            rdi_q     <= rdi_d;
            a_q       <= a_d;
            b_q       <= b_d;
            shamt_q   <= shamt_d;
            funct3_q  <= funct3_d;
            invertb_q <= invertb_d;
            illegal_q <= illegal_d;
        end
    end

    assign out_valid = valid_q;
    assign rdi       = rdi_q;
    assign a         = a_q;
    assign b         = b_q;
    assign shamt     = shamt_q;
    assign funct3    = funct3_q;
    assign invertb   = invertb_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_riscv_id.sv
// Self-checking bench for riscv_id: instruction-level reference model plus directed literals.
module tb_riscv_id;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] inst = '0;
    logic        stall = 1'b0;
    logic        wb_en = 1'b0;
    logic [4:0]  wb_rd = '0;
    logic [31:0] wb_data = '0;
    logic        out_valid;
    logic [4:0]  rdi;
    logic [31:0] a, b;
    logic [5:0]  shamt;
    logic [2:0]  funct3;
    logic        invertb;
    logic        illegal;

    int checks = 0;
    int errors = 0;

    riscv_id dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .inst      (inst),
        .stall     (stall),
        .wb_en     (wb_en),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data),
        .out_valid (out_valid),
        .rdi       (rdi),
        .a         (a),
        .b         (b),
        .shamt     (shamt),
        .funct3    (funct3),
        .invertb   (invertb),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    // Reference model: architectural registers and the expected EX-side view.
    logic [31:0] m_regs [32];
    logic        e_valid, e_inv, e_ill;
    logic [4:0]  e_rdi;
    logic [31:0] e_a, e_b;
    logic [5:0]  e_shamt;
    logic [2:0]  e_f3;

    function automatic logic [31:0] m_read(input int r);
        if (r == 0) return 32'h0;
`ifdef RISCV_WB_BYPASS_EN
        if (wb_en && int'(wb_rd) == r) return wb_data;
`endif
        return m_regs[r];
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
            {e_valid, e_inv, e_ill, e_rdi, e_a, e_b, e_shamt, e_f3} = '0;
        end else begin
            int op, f3, r1, r2;
            op = int'(inst[6:0]);
            f3 = int'(inst[14:12]);
            r1 = int'(inst[19:15]);
            r2 = int'(inst[24:20]);
            e_ill = 1'b0;
            if (!stall) begin
                if (!in_valid) begin
                    e_valid = 1'b0;
                    e_rdi   = 5'd0;
                end else if (op == 'h33 || op == 'h13) begin
                    e_valid = 1'b1;
                    e_rdi   = inst[11:7];
                    e_f3    = inst[14:12];
                    e_a     = m_read(r1);
                    if (op == 'h33) begin
                        e_b     = m_read(r2);
                        e_shamt = 6'(e_b % 32);
                        e_inv   = inst[30];
                    end else begin
                        e_b     = {{20{inst[31]}}, inst[31:20]};
                        e_shamt = 6'(r2);
                        e_inv   = (f3 == 5) ? inst[30] : 1'b0;
                    end
                end else begin
                    e_valid = 1'b0;
                    e_rdi   = 5'd0;
                    e_ill   = 1'b1;
                end
            end
            if (wb_en && wb_rd != 5'd0) m_regs[wb_rd] = wb_data;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model.
    always begin
        @(posedge clk);
        #1;
        chk("m_in_ready", 32'(in_ready), 32'(!stall));
        chk("m_out_valid", 32'(out_valid), 32'(e_valid));
        chk("m_rdi", 32'(rdi), 32'(e_rdi));
        chk("m_illegal", 32'(illegal), 32'(e_ill));
        if (e_valid) begin
            chk("m_a", a, e_a);
            chk("m_b", b, e_b);
            chk("m_shamt", 32'(shamt), 32'(e_shamt));
            chk("m_funct3", 32'(funct3), 32'(e_f3));
            chk("m_invertb", 32'(invertb), 32'(e_inv));
        end
    end

    task automatic cyc(input logic v, input logic [31:0] i, input logic s,
                       input logic we, input logic [4:0] wr, input logic [31:0] wd);
        @(negedge clk);
        in_valid = v;
        inst     = i;
        stall    = s;
        wb_en    = we;
        wb_rd    = wr;
        wb_data  = wd;
        @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] AddX3X0X0  = 32'h000001B3;
    localparam logic [31:0] AddiX6X5m3 = 32'hFFD28313;
    localparam logic [31:0] SraiX1X2_4 = 32'h40415093;
    localparam logic [31:0] SrliX1X2_4 = 32'h00415093;
    localparam logic [31:0] AndiX1X2   = 32'hC0017093;
    localparam logic [31:0] AddX9X5X2  = 32'h002284B3;
    localparam logic [31:0] SubX10X2X5 = 32'h40510533;
    localparam logic [31:0] LwX3X5     = 32'h0002A183;
    localparam logic [31:0] AddX7X4X4  = 32'h004203B3;

    logic [31:0] old_x4_or_bypass;

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_a", a, 32'h0);
        chk("rst_b", b, 32'h0);
        chk("rst_rdi_shamt_f3", {rdi, shamt, funct3}, 32'h0);
        chk("rst_inv_ill", {invertb, illegal}, 32'h0);

        // Instruction presented as reset deasserts is taken normally.
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b1;
        inst = AddX3X0X0;
        @(posedge clk);
        #1;
        chk("rst_exit_valid", {out_valid, rdi}, {1'b1, 5'd3});

        cyc(0, 32'h0, 0, 1, 5'd5, 32'h7);
        cyc(1, AddiX6X5m3, 0, 0, 5'd0, 32'h0);
        chk("addi_valid_rdi", {out_valid, rdi}, {1'b1, 5'd6});
        chk("addi_a", a, 32'h7);
        chk("addi_b", b, 32'hFFFF_FFFD);
        chk("addi_funct3", 32'(funct3), 32'h0);

        cyc(0, 32'h0, 0, 1, 5'd2, 32'h8000_0000);
        cyc(1, SraiX1X2_4, 0, 0, 5'd0, 32'h0);
        chk("srai_shamt", 32'(shamt), 32'd4);
        chk("srai_f3_inv", {funct3, invertb}, {3'b101, 1'b1});
        chk("srai_a", a, 32'h8000_0000);

        cyc(1, SrliX1X2_4, 0, 0, 5'd0, 32'h0);
        chk("srli_inv", 32'(invertb), 32'h0);
        cyc(1, AndiX1X2, 0, 0, 5'd0, 32'h0);
        chk("andi_b_inv", {b[30:0], invertb}, {31'h7FFF_FC00, 1'b0});

        cyc(0, 32'h0, 0, 1, 5'd0, 32'hDEAD_BEEF);
        cyc(1, AddX3X0X0, 0, 0, 5'd0, 32'h0);
        chk("x0_a", a, 32'h0);
        chk("x0_b", b, 32'h0);

        cyc(1, AddX9X5X2, 0, 0, 5'd0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            cyc(1, SubX10X2X5, 1, 0, 5'd0, 32'h0);
            chk("stall_ready", 32'(in_ready), 32'h0);
            chk("stall_hold_ab", a ^ b, 32'h8000_0007);
            chk("stall_hold_rdi", {out_valid, rdi, illegal}, {1'b1, 5'd9, 1'b0});
        end
        cyc(1, SubX10X2X5, 0, 0, 5'd0, 32'h0);
        chk("sub_a", a, 32'h8000_0000);
        chk("sub_b_shamt", {b[25:0], shamt}, {26'd7, 6'd7});
        chk("sub_rdi_inv", {rdi, invertb}, {5'd10, 1'b1});

        cyc(1, LwX3X5, 0, 0, 5'd0, 32'h0);
        chk("lw_illegal", {illegal, out_valid, rdi}, {1'b1, 1'b0, 5'd0});
        cyc(0, 32'h0, 0, 0, 5'd0, 32'h0);
        chk("lw_after", 32'(illegal), 32'h0);

        cyc(0, 32'h0, 0, 1, 5'd4, 32'h11);
        cyc(1, AddX7X4X4, 0, 1, 5'd4, 32'h55);
`ifdef RISCV_WB_BYPASS_EN
        old_x4_or_bypass = 32'h55;
`else
        old_x4_or_bypass = 32'h11;
`endif
        chk("bypass_a", a, old_x4_or_bypass);
        chk("bypass_b", b, old_x4_or_bypass);
        cyc(1, AddX7X4X4, 0, 0, 5'd0, 32'h0);
        chk("x4_written", a, 32'h55);

        // Reset during a stall drops the held instruction and clears registers.
        cyc(1, AddX9X5X2, 0, 0, 5'd0, 32'h0);
        cyc(1, SubX10X2X5, 1, 0, 5'd0, 32'h0);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_valid_rdi", {out_valid, rdi}, 32'h0);
        chk("midrst_a", a, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        stall = 1'b0;
        in_valid = 1'b0;
        cyc(1, AddX9X5X2, 0, 0, 5'd0, 32'h0);
        chk("midrst_regs", a | b, 32'h0);
        chk("midrst_rdi", {out_valid, rdi}, {1'b1, 5'd9});

        cyc(0, 32'h0, 0, 0, 5'd0, 32'h0);
        chk("bubble", {out_valid, rdi, illegal}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
